grayscale_word_packer: RTL
==========================

# grayscale_word_packer

Downstream stage of the RGB565-to-grayscale converter in the camera path: accepts one 8-bit grayscale pixel per cycle and packs four consecutive pixels into a 32-bit little-endian word. Buffers words in a first-word-fall-through FIFO and presents them on a valid/ready interface to the DMA/bus-master that writes the grayscale frame buffer. Frame framing, flush of partial words, overflow detection and per-frame word counting are handled here.

## Interface
- FIFO_DEPTH, 16, number of 32-bit words buffered; power of two, at least 4
- COUNT_WIDTH, 16, width of the per-frame word counter
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- frame_start  input  1  single-cycle pulse marking the start of a frame
- frame_end  input  1  single-cycle pulse marking the end of a frame
- pixel_valid  input  1  grayscale carries a valid pixel this cycle
- grayscale  input  8  pixel value from the grayscale converter
- word_valid  output  1  word_data holds a valid word (FIFO not empty)
- word_data  output  32  FIFO head; byte 0 = oldest pixel
- word_ready  input  1  consumer accepts word_data this cycle
- fifo_level  output  log2(FIFO_DEPTH)+1  words currently in FIFO
- overflow  output  1  sticky: a word was dropped because the FIFO was full
- words_packed  output  COUNT_WIDTH  words pushed into the FIFO since frame_start
- frame_done  output  1  one-cycle pulse when frame_end processing is complete

## Operation
- States: IDLE, ACTIVE, FLUSH. Reset -> IDLE.
- IDLE: pixel_valid and frame_end ignored. frame_start -> ACTIVE.
- ACTIVE: on pixel_valid, grayscale written into byte lane byte_index of the accumulator; byte_index increments mod 4. When byte_index was 3, the completed word {pix3,pix2,pix1,pix0} is pushed.
- ACTIVE + frame_end -> FLUSH. A pixel_valid in the same cycle is packed first.
- FLUSH (one cycle): if byte_index != 0, push the partial word with unwritten upper lanes zero; byte_index cleared; frame_done pulses; -> IDLE.
- frame_start in any state: byte_index and accumulator cleared, overflow and words_packed cleared, -> ACTIVE. frame_start has priority over frame_end and pixel_valid in the same cycle (that pixel is discarded). FIFO contents are never cleared except by reset.
- Push accepted if FIFO not full, or full with a pop in the same cycle. Otherwise the word is dropped, overflow set, words_packed not incremented.
- Pop when word_valid && word_ready. Pointers wrap modulo FIFO_DEPTH; fifo_level = pushes - pops, never exceeds FIFO_DEPTH.
- words_packed increments once per accepted push and saturates at all ones.
- word_data is undefined-but-stable (holds last head) when word_valid is 0; consumers must not sample it.

## Timing
- Reset values: word_valid 0, word_data 0, fifo_level 0, overflow 0, words_packed 0, frame_done 0; state IDLE, byte_index 0.
- Fourth pixel sampled at edge N -> word pushed at edge N; word_valid (if FIFO was empty) high after edge N, i.e. visible in cycle N+1.
- frame_end at edge N -> FLUSH in cycle N+1; partial word pushed and frame_done high for cycle N+1 only; word_valid visible cycle N+2.
- Pixel throughput: one per cycle sustained; words one per four cycles; consumer may stall arbitrarily.
- Simultaneous push and pop with FIFO empty: not possible (word_valid is 0); push proceeds.
- Reset asserted mid-frame: all state and FIFO contents lost immediately, outputs return to reset values asynchronously.

## Test plan
- Reset, frame_start, pixels 0x11,0x22,0x33,0x44 back-to-back, word_ready=1 -> one word 0x44332211, word_valid one cycle after fourth pixel, words_packed=1.
- frame_start, 6 pixels 0x01..0x06, frame_end -> words 0x04030201 then 0x00000605; frame_done single pulse; words_packed=2.
- word_ready=0, frame of 4*(FIFO_DEPTH+2) pixels -> fifo_level=FIFO_DEPTH, overflow=1, words_packed=FIFO_DEPTH; release ready -> exactly FIFO_DEPTH words in order.
- FIFO full, push coinciding with pop -> push accepted, no overflow, fifo_level unchanged.
- Pixels before frame_start and after frame_end -> ignored, no words; frame_start mid-word (2 pixels buffered) -> partial bytes discarded, next 4 pixels form a clean word, overflow/words_packed cleared.
- Assert reset while FIFO holds 3 words -> word_valid=0, fifo_level=0 immediately, no stale word after release.

Source files
------------

// File: rtl/grayscale_word_packer.sv
// grayscale_word_packer
// Packs four consecutive 8-bit grayscale pixels into one little-endian 32-bit
// word and buffers the words in a first-word-fall-through FIFO for the
// frame-buffer DMA. Handles frame framing, partial-word flush, overflow
// reporting and per-frame word counting.
//
// Handshake: a word moves from the FIFO to the consumer on every rising edge
// where word_valid && word_ready are both high. word_valid never depends on
// word_ready, and word_data stays stable while word_valid is high and
// word_ready is low.
module grayscale_word_packer #(
   parameter int FIFO_DEPTH  = 16,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          frame_start,
   input  logic                          frame_end,
   input  logic                          pixel_valid,
   input  logic [7:0]                    grayscale,
   output logic                          word_valid,
   output logic [31:0]                   word_data,
   input  logic                          word_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic [COUNT_WIDTH-1:0]        words_packed,
   output logic                          frame_done,
   output logic [1:0]                    debug_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] LEVEL_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  byte_index, byte_index_nxt;
   // Lanes 0..2 of the word being built; lane 3 goes straight into the push.
   logic [23:0] acc, acc_nxt;
   logic        push;
   logic [31:0] push_data;
   logic        clear_frame;
   logic        frame_done_c;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level;
   logic [31:0]   last_head;
   logic          pop;
   logic          push_ok;
   logic          drop;

   // Next-state, accumulator update and push request for the packing FSM.
   always_comb begin
      state_nxt      = state;
      byte_index_nxt = byte_index;
      acc_nxt        = acc;
      push           = 1'b0;
      push_data      = 32'd0;
      clear_frame    = 1'b0;
      frame_done_c   = 1'b0;
      if (frame_start) begin
         // A new frame wins over everything else, discarding any pixel
         // arriving in the same cycle and any partially built word.
         state_nxt      = ACTIVE;
         byte_index_nxt = 2'd0;
         acc_nxt        = 24'd0;
         clear_frame    = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = IDLE;
            end
            ACTIVE: begin
               if (pixel_valid) begin
                  byte_index_nxt = byte_index + 2'd1;
                  case (byte_index)
                     2'd0: acc_nxt[7:0]   = grayscale;
                     2'd1: acc_nxt[15:8]  = grayscale;
                     2'd2: acc_nxt[23:16] = grayscale;
                     default: begin
                        push      = 1'b1;
                        push_data = {grayscale, acc};
                        acc_nxt   = 24'd0;
                     end
                  endcase
               end
               if (frame_end) begin
                  state_nxt = FLUSH;
               end
            end
            FLUSH: begin
               // Unwritten lanes are already zero because acc is cleared
               // after every completed word and at frame start.
               frame_done_c = 1'b1;
               if (byte_index != 2'd0) begin
                  push      = 1'b1;
                  push_data = {8'd0, acc};
               end
               byte_index_nxt = 2'd0;
               acc_nxt        = 24'd0;
               state_nxt      = IDLE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Packing FSM state, byte lane pointer and accumulator.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         byte_index <= 2'd0;
         acc        <= 24'd0;
      end else begin
         state      <= state_nxt;
         byte_index <= byte_index_nxt;
         acc        <= acc_nxt;
      end
   end

   assign word_valid = (level != '0);
   assign pop        = word_valid && word_ready;
   // A full FIFO still takes a word when the head leaves in the same cycle.
   assign push_ok    = push && ((level != LEVEL_FULL) || pop);
   assign drop       = push && !push_ok;

   // FIFO storage; contents are only meaningful between rd_ptr and wr_ptr.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // FIFO pointers, occupancy and the held copy of the last popped head.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         last_head <= 32'd0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            last_head <= mem[rd_ptr];
         end
         case ({push_ok, pop})
            2'b10:   level <= level + LEVEL_ONE;
            2'b01:   level <= level - LEVEL_ONE;
            default: level <= level;
         endcase
      end
   end

   // Per-frame statistics: sticky overflow and saturating word count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow     <= 1'b0;
         words_packed <= '0;
      end else if (clear_frame) begin
         overflow     <= 1'b0;
         words_packed <= '0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
         end
         if (push_ok && (words_packed != '1)) begin
            words_packed <= words_packed + COUNT_ONE;
         end
      end
   end

   assign word_data   = word_valid ? mem[rd_ptr] : last_head;
   assign fifo_level  = level;
   assign frame_done  = frame_done_c;
   assign debug_state = state;

endmodule
